exec_mem_unit: RTL and testbench

- Combined execute/memory datapath slice of the single-cycle MIPS core.
- Decodes the 2-bit ALU operation class plus the R-type funct field into an ALU control code.
- Performs the 32-bit ALU operation and flags jr for the PC-select logic.
- Holds the word-addressed data memory addressed by the ALU result.
- Sits between the register file/immediate mux and the write-back mux.

---
 rtl/exec_mem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 29 ++
 rtl/exec_mem_unit.sv | 111 +++++++++++
 tb/tb_exec_mem_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_mem_pkg.sv
// Shared constants and types for the execute/memory slice: ALU operation classes,
// R-type funct codes and the 4-bit ALU control encoding.
package exec_mem_pkg;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_NOR = 4'b1100
    } alu_ctrl_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data memory: synchronous clear and write, combinational read.
module dmem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Reset wins over a write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the single-cycle MIPS core: ALU control decode, 32-bit ALU and
// data memory. Define EXEC_MEM_OVF_EN to add the signed-overflow output ovf.
module exec_mem_unit
    import exec_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] wdata,
    input  logic        memread,
    input  logic        memwrite,
    output logic [3:0]  alu_ctrl,
    output logic        jump_reg,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] rdata
`ifdef EXEC_MEM_OVF_EN
    ,
    output logic        ovf
`endif
);

    alu_ctrl_t   ctrl;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] mem_rdata;

    always_comb begin
        ctrl     = ALU_ADD;
        jump_reg = 1'b0;
        case (aluop)
            ALUOP_MEM: ctrl = ALU_ADD;
            ALUOP_BR:  ctrl = ALU_SUB;
            ALUOP_ORI: ctrl = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_NOR: ctrl = ALU_NOR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    FUNCT_SLL: ctrl = ALU_SLL;
                    FUNCT_SRL: ctrl = ALU_SRL;
                    FUNCT_JR: begin
                        // jr still computes rs + rt; the PC mux only needs the flag.
                        ctrl     = ALU_ADD;
                        jump_reg = 1'b1;
                    end
                    default:   ctrl = ALU_ADD;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
    end

    assign alu_ctrl = ctrl;
    assign sum      = op_a + op_b;
    assign diff     = op_a - op_b;

    always_comb begin
        alu_result = '0;
        case (ctrl)
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_ADD: alu_result = sum;
            ALU_SUB: alu_result = diff;
            ALU_SLT: alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLL: alu_result = op_b << shamt;
            ALU_SRL: alu_result = op_b >> shamt;
            ALU_NOR: alu_result = ~(op_a | op_b);
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == 32'h0);

`ifdef EXEC_MEM_OVF_EN
    always_comb begin
        ovf = 1'b0;
        case (ctrl)
            ALU_ADD: ovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
            ALU_SUB: ovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
            default: ovf = 1'b0;
        endcase
    end
`endif

    // Byte address -> word index; offset and upper bits drop out, so addresses wrap.
    dmem_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_dmem (
        .clk  (clk),
        .reset(reset),
        .we   (memwrite),
        .addr (alu_result[AW+1:2]),
        .wdata(wdata),
        .rdata(mem_rdata)
    );

    assign rdata = memread ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: directed cases followed by random stimulus
// compared against a behavioural model of the ALU and data memory.
module tb_exec_mem_unit;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] wdata;
    logic        memread;
    logic        memwrite;
    logic [3:0]  alu_ctrl;
    logic        jump_reg;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] rdata;
`ifdef EXEC_MEM_OVF_EN
    logic        ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    exec_mem_unit #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .aluop     (aluop),
        .funct     (funct),
        .shamt     (shamt),
        .op_a      (op_a),
        .op_b      (op_b),
        .wdata     (wdata),
        .memread   (memread),
        .memwrite  (memwrite),
        .alu_ctrl  (alu_ctrl),
        .jump_reg  (jump_reg),
        .alu_result(alu_result),
        .zero      (zero),
        .rdata     (rdata)
`ifdef EXEC_MEM_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Behavioural model: operation named from the opcode class, then plain arithmetic.
    function automatic logic [3:0] ref_ctrl(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'd0) return 4'h2;
        if (aop == 2'd1) return 4'h6;
        if (aop == 2'd3) return 4'h1;
        case (fn)
            6'h20:   return 4'h2;
            6'h22:   return 4'h6;
            6'h24:   return 4'h0;
            6'h25:   return 4'h1;
            6'h27:   return 4'hC;
            6'h2A:   return 4'h7;
            6'h00:   return 4'h8;
            6'h02:   return 4'h9;
            default: return 4'h2;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'h8:    return b << sh;
            4'h9:    return b >> sh;
            4'hC:    return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] c, input logic [31:0] a,
                                     input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        if (c == 4'h2) r = sa + sb;
        else if (c == 4'h6) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic int ref_index(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    task automatic drive(input logic rst, input logic [1:0] aop, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] wd, input logic mr, input logic mw);
        reset = rst; aluop = aop; funct = fn; shamt = sh;
        op_a = a; op_b = b; wdata = wd; memread = mr; memwrite = mw;
        #1;
    endtask

    // Check every output against the model, then advance one edge and update the model.
    task automatic cycle_check();
        logic [3:0]  c;
        logic [31:0] r;
        @(negedge clk);
        c = ref_ctrl(aluop, funct);
        r = ref_alu(c, op_a, op_b, shamt);
        check("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, c});
        check("jump_reg", {31'b0, jump_reg}, {31'b0, (aluop == 2'd2 && funct == 6'h08)});
        check("alu_result", alu_result, r);
        check("zero", {31'b0, zero}, {31'b0, (r == 32'h0)});
        check("rdata", rdata, memread ? ref_mem[ref_index(r)] : 32'h0);
`ifdef EXEC_MEM_OVF_EN
        check("ovf", {31'b0, ovf}, {31'b0, ref_ovf(c, op_a, op_b)});
`endif
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        end else if (memwrite) begin
            ref_mem[ref_index(r)] = wdata;
        end
        #1;
    endtask

    logic [5:0] fn_list [10];

    initial begin
        fn_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        drive(1'b1, 2'd0, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Write attempted during reset is discarded.
        drive(1'b1, 2'd0, 6'h0, 5'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        cycle_check();
        drive(1'b0, 2'd0, 6'h0, 5'd0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        cycle_check();

        drive(1'b0, 2'd2, 6'h20, 5'd0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0);
        check("add_ctrl", {28'b0, alu_ctrl}, 32'h2);
        check("add_res", alu_result, 32'd12);
        check("add_zero", {31'b0, zero}, 32'h0);
        cycle_check();
        drive(1'b0, 2'd2, 6'h22, 5'd0, 32'd9, 32'd9, 32'h0, 1'b0, 1'b0);
        check("sub_res", alu_result, 32'h0);
        check("sub_zero", {31'b0, zero}, 32'h1);
        cycle_check();
        drive(1'b0, 2'd2, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0);
        check("slt_res", alu_result, 32'd1);
        cycle_check();
        drive(1'b0, 2'd2, 6'h00, 5'd4, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0);
        check("sll_res", alu_result, 32'h10);
        cycle_check();
        drive(1'b0, 2'd2, 6'h27, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("nor_res", alu_result, 32'hFFFF_FFFF);
        cycle_check();
        drive(1'b0, 2'd2, 6'h08, 5'd0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        check("jr_flag", {31'b0, jump_reg}, 32'h1);
        check("jr_ctrl", {28'b0, alu_ctrl}, 32'h2);
        cycle_check();
        drive(1'b0, 2'd0, 6'h08, 5'd0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        check("nojr_flag", {31'b0, jump_reg}, 32'h0);
        cycle_check();

        drive(1'b0, 2'd0, 6'h0, 5'd0, 32'h100, 32'd4, 32'hCAFEF00D, 1'b0, 1'b1);
        cycle_check();
        drive(1'b0, 2'd0, 6'h0, 5'd0, 32'h100, 32'd4, 32'h0, 1'b1, 1'b0);
        check("mem_rd", rdata, 32'hCAFEF00D);
        cycle_check();
        drive(1'b0, 2'd0, 6'h0, 5'd0, 32'h100 + 4 * DEPTH, 32'd4, 32'h0, 1'b1, 1'b0);
        check("mem_wrap", rdata, 32'hCAFEF00D);
        cycle_check();
        drive(1'b0, 2'd0, 6'h0, 5'd0, 32'h100, 32'd4, 32'h0, 1'b0, 1'b0);
        check("mem_nord", rdata, 32'h0);
        cycle_check();

`ifdef EXEC_MEM_OVF_EN
        drive(1'b0, 2'd2, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0);
        check("ovf_add_res", alu_result, 32'h8000_0000);
        check("ovf_add", {31'b0, ovf}, 32'h1);
        cycle_check();
        drive(1'b0, 2'd2, 6'h22, 5'd0, 32'h8000_0000, 32'd1, 32'h0, 1'b0, 1'b0);
        check("ovf_sub", {31'b0, ovf}, 32'h1);
        cycle_check();
        drive(1'b0, 2'd2, 6'h24, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        check("ovf_and", {31'b0, ovf}, 32'h0);
        cycle_check();
`endif

        for (int n = 0; n < 500; n++) begin
            logic [1:0]  aop;
            logic [31:0] a;
            aop = 2'($urandom_range(0, 3));
            a   = $urandom;
            if (aop == 2'd0) a = a & 32'h0000_03FF;
            drive(($urandom_range(0, 39) == 0), aop, fn_list[$urandom_range(0, 9)],
                  5'($urandom), a, (aop == 2'd0) ? ($urandom & 32'h3FF) : $urandom,
                  $urandom, 1'($urandom), 1'($urandom));
            cycle_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
